// File: rtl/cordic_pkg.sv
// Constants and types shared by the rotation and vectoring CORDIC units.
package cordic_pkg;

    localparam logic [31:0] QUARTER_TURN = 32'h4000_0000;
    localparam logic [15:0] GAIN_INV_Q15 = 16'd19898;
    localparam int unsigned ATAN_ENTRIES = 31;

    // atan(2^-i) in binary-angle units (2^32 = one full turn)
    localparam logic [31:0] ATAN_TABLE [ATAN_ENTRIES] = '{
        32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
        32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
        32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
        32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
        32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
        32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
        32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
        32'h0000_0003, 32'h0000_0001, 32'h0000_0001
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ITER  = 2'd1,
        SCALE = 2'd2,
        DONE  = 2'd3
    } cordic_state_t;

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup for CORDIC micro-rotation i.
module cordic_atan_rom
    import cordic_pkg::*;
(
    input  logic [4:0]  idx,
    output logic [31:0] atan_c
);

    always_comb begin
        atan_c = '0;
        if (32'(idx) < ATAN_ENTRIES) begin
            atan_c = ATAN_TABLE[idx];
        end
    end

endmodule

// File: rtl/cordic_r.sv
// Iterative rotation-mode CORDIC, one micro-rotation per clock.
// Define CORDIC_R_GAIN_COMP_EN to add a SCALE state that removes the CORDIC gain.
module cordic_r
    import cordic_pkg::*;
#(
    parameter int unsigned width = 16,
    parameter int unsigned ITERS = width - 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [width-1:0] x_start,
    input  logic signed [width-1:0] y_start,
    input  logic signed [31:0]      angle,
    output logic                    busy,
    output logic                    done,
    output logic signed [width+1:0] x_end,
    output logic signed [width+1:0] y_end,
    output logic        [31:0]      z_res
);

    localparam int unsigned XW = width + 2;
    localparam logic [4:0]  LAST_ITER = 5'(ITERS - 1);

    cordic_state_t state, state_nx;

    logic signed [XW-1:0] x, y, x_nx, y_nx, x_ld, y_ld;
    logic        [31:0]   z, z_nx, z_ld;
    logic        [4:0]    cnt;
    logic        [31:0]   atan_c;
    logic                 load_c, last_c;

    cordic_atan_rom u_atan_rom (
        .idx    (cnt),
        .atan_c (atan_c)
    );

    assign load_c = start && ((state == IDLE) || (state == DONE));
    assign last_c = (state == ITER) && (cnt == LAST_ITER);

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = ITER;
            ITER: begin
                if (last_c) begin
`ifdef CORDIC_R_GAIN_COMP_EN
                    state_nx = SCALE;
`else
                    state_nx = DONE;
`endif
                end
            end
            SCALE: state_nx = DONE;
            DONE: state_nx = start ? ITER : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx == ITER) || (state_nx == SCALE);
            done  <= (state_nx == DONE);
        end
    end

    // Quadrant fold brings the angle into +-90 deg, inside CORDIC convergence range
    always_comb begin
        x_ld = XW'(x_start);
        y_ld = XW'(y_start);
        z_ld = angle;
        case (angle[31:30])
            2'b01: begin
                x_ld = -XW'(y_start);
                y_ld = XW'(x_start);
                z_ld = angle - QUARTER_TURN;
            end
            2'b10: begin
                x_ld = XW'(y_start);
                y_ld = -XW'(x_start);
                z_ld = angle + QUARTER_TURN;
            end
            default: ;
        endcase
    end

    // One micro-rotation, direction chosen by the sign of the residual angle
    always_comb begin
        if (!z[31]) begin
            x_nx = x - (y >>> cnt);
            y_nx = y + (x >>> cnt);
            z_nx = z - atan_c;
        end else begin
            x_nx = x + (y >>> cnt);
            y_nx = y - (x >>> cnt);
            z_nx = z + atan_c;
        end
    end

`ifdef CORDIC_R_GAIN_COMP_EN
    localparam int unsigned        PW       = XW + 16;
    localparam logic signed [PW-1:0] GAIN_EXT = $signed(PW'(GAIN_INV_Q15));

    logic signed [PW-1:0] px_c, py_c;

    assign px_c = PW'(x) * GAIN_EXT;
    assign py_c = PW'(y) * GAIN_EXT;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            x     <= '0;
            y     <= '0;
            z     <= '0;
            cnt   <= '0;
            x_end <= '0;
            y_end <= '0;
            z_res <= '0;
        end else if (load_c) begin
            x   <= x_ld;
            y   <= y_ld;
            z   <= z_ld;
            cnt <= '0;
        end else if (state == ITER) begin
            x   <= x_nx;
            y   <= y_nx;
            z   <= z_nx;
            cnt <= cnt + 5'd1;
`ifndef CORDIC_R_GAIN_COMP_EN
            if (last_c) begin
                x_end <= x_nx;
                y_end <= y_nx;
                z_res <= z_nx;
            end
`endif
        end
`ifdef CORDIC_R_GAIN_COMP_EN
        else if (state == SCALE) begin
            x_end <= XW'(px_c >>> 15);
            y_end <= XW'(py_c >>> 15);
            z_res <= z;
        end
`endif
    end

endmodule

// File: tb/tb_cordic_r.sv
// Directed self-checking bench for cordic_r (width=16, ITERS=15).
module tb_cordic_r;

    localparam int W = 16;

`ifdef CORDIC_R_GAIN_COMP_EN
    localparam int LAT    = 16;
    localparam int BUSY_N = 16;
    localparam int E_ID   = 10000;
    localparam int E_45   = 7071;
    localparam int E_EXT  = 46341;
`else
    localparam int LAT    = 15;
    localparam int BUSY_N = 15;
    localparam int E_ID   = 16468;
    localparam int E_45   = 11645;
    localparam int E_EXT  = 76313;
`endif
    localparam int ZTOL = 262144;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  start;
    logic signed [W-1:0]   x_start, y_start;
    logic        [31:0]    angle;
    logic                  busy, done;
    logic signed [W+1:0]   x_end, y_end;
    logic        [31:0]    z_res;

    int checks = 0;
    int errors = 0;
    int lat, bcnt, pulses;

    cordic_r #(.width(W), .ITERS(W - 1)) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .x_start (x_start),
        .y_start (y_start),
        .angle   (angle),
        .busy    (busy),
        .done    (done),
        .x_end   (x_end),
        .y_end   (y_end),
        .z_res   (z_res)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input longint obs, input longint exp, input longint tol);
        checks++;
        if (obs < exp - tol || obs > exp + tol) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d +-%0d", tag, obs, exp, tol);
        end
    endtask

    task automatic start_op(input int xs, input int ys, input logic [31:0] a);
        @(negedge clock);
        x_start = W'(xs);
        y_start = W'(ys);
        angle   = a;
        start   = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    // Called 1 time unit after the accepting edge; counts edges until done
    task automatic wait_done(output int n, output int bn);
        n  = 0;
        bn = 0;
        while (!done && n < 40) begin
            if (busy) bn++;
            @(posedge clock);
            #1;
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout: done not seen within %0d cycles", n);
        end
    endtask

    task automatic run_and_check(input string tag, input int xs, input int ys, input logic [31:0] a,
                                 input int ex, input int ey, input int tol);
        start_op(xs, ys, a);
        wait_done(lat, bcnt);
        check({tag, "_lat"}, lat, LAT, 0);
        check({tag, "_x"}, x_end, ex, tol);
        check({tag, "_y"}, y_end, ey, tol);
        check({tag, "_z"}, $signed(z_res), 0, ZTOL);
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        x_start = '0;
        y_start = '0;
        angle   = '0;
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", busy, 0, 0);
        check("rst_done", done, 0, 0);
        check("rst_x", x_end, 0, 0);
        check("rst_y", y_end, 0, 0);
        check("rst_z", z_res, 0, 0);
        @(negedge clock);
        reset = 1'b0;

        // Identity, with latency, busy length and single-cycle done
        start_op(10000, 0, 32'h0000_0000);
        wait_done(lat, bcnt);
        check("id_lat", lat, LAT, 0);
        check("id_busy_cycles", bcnt, BUSY_N, 0);
        check("id_busy_at_done", busy, 0, 0);
        check("id_x", x_end, E_ID, 4);
        check("id_y", y_end, 0, 4);
        check("id_z", $signed(z_res), 0, ZTOL);
        @(posedge clock);
        #1;
        check("id_done_pulse", done, 0, 0);
        check("id_hold_x", x_end, E_ID, 4);

        run_and_check("deg45", 10000, 0, 32'h2000_0000, E_45, E_45, 4);
        run_and_check("deg90", 10000, 0, 32'h4000_0000, 0, E_ID, 4);
        run_and_check("deg180", 10000, 0, 32'h8000_0000, -E_ID, 0, 4);
        run_and_check("extreme", -32768, -32768, 32'h6000_0000, E_EXT, 0, 8);

        // start pulsed mid-rotation with other operands must be ignored
        start_op(10000, 0, 32'h0000_0000);
        repeat (4) begin
            @(posedge clock);
            #1;
        end
        @(negedge clock);
        x_start = 16'sd5;
        y_start = 16'sd7;
        angle   = 32'h2000_0000;
        start   = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_done(lat, bcnt);
        check("ign_lat", lat + 5, LAT, 0);
        check("ign_x", x_end, E_ID, 4);
        check("ign_y", y_end, 0, 4);

        // start held through DONE: back-to-back operation
        @(negedge clock);
        x_start = 16'sd10000;
        y_start = 16'sd0;
        angle   = 32'h0000_0000;
        start   = 1'b1;
        @(posedge clock);
        #1;
        angle = 32'h4000_0000;
        wait_done(lat, bcnt);
        check("b2b_first_lat", lat, LAT, 0);
        check("b2b_first_x", x_end, E_ID, 4);
        check("b2b_first_y", y_end, 0, 4);
        @(posedge clock);
        #1;
        start = 1'b0;
        check("b2b_restart_busy", busy, 1, 0);
        check("b2b_restart_done", done, 0, 0);
        wait_done(lat, bcnt);
        check("b2b_second_lat", lat, LAT, 0);
        check("b2b_second_x", x_end, 0, 4);
        check("b2b_second_y", y_end, E_ID, 4);

        // Reset during iteration 7 aborts with no done pulse
        start_op(10000, 0, 32'h2000_0000);
        repeat (7) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("abort_busy", busy, 0, 0);
        check("abort_x", x_end, 0, 0);
        check("abort_y", y_end, 0, 0);
        check("abort_z", z_res, 0, 0);
        pulses = 0;
        repeat (30) begin
            @(posedge clock);
            #1;
            if (done) pulses++;
        end
        check("abort_no_done", pulses, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
